// File: rtl/seq_pkg.sv
// Shared constants and helpers for the sequence-processing datapath blocks.
package seq_pkg;

  localparam int DW_DEF        = 8;
  localparam int MAX_LOG_W_DEF = 4;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Requested window exponents beyond the supported depth fall back to the maximum.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned max_log);
    return (sel > max_log) ? max_log : sel;
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Shift register of accepted samples; tap 0 is the newest, exposed as one flat vector.
module sample_delay_line #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic [DW-1:0]       din,
  output logic [DEPTH*DW-1:0] taps
);

  logic [DEPTH*DW-1:0] r_taps;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst)           r_taps <= '0;
        else if (shift_en) r_taps <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst)           r_taps <= '0;
        else if (shift_en) r_taps <= {r_taps[(DEPTH-1)*DW-1:0], din};
      end
    end
  endgenerate

  assign taps = r_taps;

endmodule

// File: rtl/past_window_accumulator.sv
// Running sum or floor mean of the last 2^win_sel accepted samples, using one
// add/subtract per sample and a registered, valid-tagged result.
module past_window_accumulator
  import seq_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int MAX_LOG_W = MAX_LOG_W_DEF,
  parameter int SEL_W     = 3,
  parameter int OUT_DW    = DW + MAX_LOG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     inp,
  input  logic [SEL_W-1:0]  win_sel,
  input  logic              mean_en,
  output logic              out_valid,
  output logic [OUT_DW-1:0] outp,
  output logic              full
);

  localparam int FW    = MAX_LOG_W + 1;
  localparam int DEPTH = 1 << MAX_LOG_W;

  logic [SEL_W-1:0]     r_win_q;
  logic [FW-1:0]        r_fill;
  logic [OUT_DW-1:0]    r_acc;
  logic [OUT_DW-1:0]    r_outp;
  logic                 r_out_valid;
  logic                 r_full;

  logic [DEPTH*DW-1:0]  w_taps;
  logic [SEL_W-1:0]     w_sel_c;
  logic                 w_change;
  logic [FW-1:0]        w_win_cur;
  logic [FW-1:0]        w_win_nxt;
  logic [MAX_LOG_W-1:0] w_old_idx;
  logic [DW-1:0]        w_old;
  logic                 w_at_full;
  logic [OUT_DW-1:0]    w_acc_nxt;
  logic [FW-1:0]        w_fill_nxt;

  function automatic logic [OUT_DW-1:0] f_mean(input logic [OUT_DW-1:0] a,
                                                input logic [SEL_W-1:0]  sh);
    return a >> sh;
  endfunction

  sample_delay_line #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .shift_en (in_valid),
    .din      (inp),
    .taps     (w_taps)
  );

  assign w_sel_c   = SEL_W'(clamp_sel(32'(win_sel), MAX_LOG_W));
  assign w_change  = (w_sel_c != r_win_q);
  assign w_win_cur = FW'(1) << r_win_q;
  assign w_win_nxt = FW'(1) << w_sel_c;
  assign w_old_idx = MAX_LOG_W'(w_win_cur - FW'(1));
  assign w_old     = w_taps[w_old_idx*DW +: DW];
  assign w_at_full = (r_fill == w_win_cur);

  // A window change restarts the window, so the incoming sample (if any) stands alone.
  always_comb begin
    w_acc_nxt  = r_acc + OUT_DW'(inp) - (w_at_full ? OUT_DW'(w_old) : '0);
    w_fill_nxt = w_at_full ? r_fill : r_fill + FW'(1);
    if (w_change) begin
      w_acc_nxt  = OUT_DW'(inp);
      w_fill_nxt = FW'(1);
    end
  end

  // Stage boundary: accumulator, fill counter and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_q     <= w_sel_c;
      r_acc       <= '0;
      r_fill      <= '0;
      r_outp      <= '0;
      r_out_valid <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      r_win_q <= w_sel_c;
      if (in_valid) begin
        r_acc       <= w_acc_nxt;
        r_fill      <= w_fill_nxt;
        r_outp      <= mean_en ? f_mean(w_acc_nxt, w_sel_c) : w_acc_nxt;
        r_out_valid <= 1'b1;
        r_full      <= (w_fill_nxt == w_win_nxt);
      end else begin
        r_out_valid <= 1'b0;
        if (w_change) begin
          r_acc  <= '0;
          r_fill <= '0;
          r_full <= 1'b0;
        end
      end
    end
  end

  assign outp      = r_outp;
  assign out_valid = r_out_valid;
  assign full      = r_full;

endmodule

// File: tb/tb_past_window_accumulator.sv
// Randomized and directed bench for past_window_accumulator against a queue-based window model.
module tb_past_window_accumulator;

  localparam int DW        = 8;
  localparam int MAX_LOG_W = 4;
  localparam int SEL_W     = 3;
  localparam int OUT_DW    = DW + MAX_LOG_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DW-1:0]     inp;
  logic [SEL_W-1:0]  win_sel;
  logic              mean_en;
  logic              out_valid;
  logic [OUT_DW-1:0] outp;
  logic              full;

  past_window_accumulator #(
    .DW        (DW),
    .MAX_LOG_W (MAX_LOG_W),
    .SEL_W     (SEL_W),
    .OUT_DW    (OUT_DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inp       (inp),
    .win_sel   (win_sel),
    .mean_en   (mean_en),
    .out_valid (out_valid),
    .outp      (outp),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: samples accepted since the last flush, newest first.
  int                hist[$];
  int                mw;
  logic [OUT_DW-1:0] exp_outp;
  logic              exp_valid;
  logic              exp_full;
  bit                exp_ready;

  // Literal pins, requested by the stimulus and checked by the compare process.
  int pin_id;
  int pin_seen;
  int pin_outp;
  int pin_full;

  int n_cmp;
  int n_bad;
  int cyc_no;

  function automatic int clampm(input int s);
    return (s > MAX_LOG_W) ? MAX_LOG_W : s;
  endfunction

  task automatic cyc(input bit r, input bit v, input int d, input int sel, input bit m);
    int nw, w, s;
    rst      = r;
    in_valid = v;
    inp      = DW'(d);
    win_sel  = SEL_W'(sel);
    mean_en  = m;
    @(posedge clk);
    #1;
    nw = clampm(sel);
    if (r) begin
      hist.delete();
      mw        = nw;
      exp_outp  = '0;
      exp_valid = 1'b0;
      exp_full  = 1'b0;
    end else begin
      if (nw != mw) begin
        hist.delete();
        mw       = nw;
        exp_full = 1'b0;
      end
      if (v) begin
        hist.push_front(d);
        if (hist.size() > (1 << MAX_LOG_W)) void'(hist.pop_back());
        w = 1 << mw;
        s = 0;
        for (int i = 0; i < hist.size() && i < w; i++) s += hist[i];
        exp_outp  = OUT_DW'(m ? (s >> mw) : s);
        exp_valid = 1'b1;
        exp_full  = (hist.size() >= w);
      end else begin
        exp_valid = 1'b0;
      end
    end
    exp_ready = 1'b1;
    cyc_no++;
  endtask

  task automatic pin(input int o, input int f);
    pin_outp = o;
    pin_full = f;
    pin_id++;
  endtask

  always @(negedge clk) begin
    if (exp_ready) begin
      n_cmp++;
      if (out_valid !== exp_valid || outp !== exp_outp || full !== exp_full) begin
        n_bad++;
        $display("FAIL cycle %0d: got valid=%b outp=%0d full=%b, expected valid=%b outp=%0d full=%b",
                 cyc_no, out_valid, outp, full, exp_valid, exp_outp, exp_full);
      end
    end
    if (pin_id != pin_seen) begin
      pin_seen = pin_id;
      n_cmp++;
      if (int'(outp) != pin_outp || (pin_full >= 0 && int'(full) != pin_full)) begin
        n_bad++;
        $display("FAIL pin %0d: got outp=%0d full=%b, expected outp=%0d full=%0d",
                 pin_id, outp, full, pin_outp, pin_full);
      end
    end
  end

  initial begin
    int sel, m, d;
    int exp4[6];
    int expm[6];
    exp4 = '{1, 3, 6, 10, 14, 18};
    expm = '{0, 0, 1, 2, 3, 4};
    rst = 1'b1; in_valid = 1'b0; inp = '0; win_sel = 3'd2; mean_en = 1'b0;
    mw = 2; exp_ready = 1'b0; pin_id = 0; pin_seen = 0;
    n_cmp = 0; n_bad = 0; cyc_no = 0;

    // Reset state and W=4 raw sums
    cyc(1, 0, 0, 2, 0);
    cyc(1, 0, 0, 2, 0);
    pin(0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, i + 1, 2, 0);
      pin(exp4[i], (i >= 3) ? 1 : 0);
    end

    // W=4 floor mean, then refill with 8s
    cyc(1, 0, 0, 2, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, i + 1, 2, 1);
      pin(expm[i], -1);
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 8, 2, 1);
    pin(8, 1);

    // W=16 of full-scale samples with idle gaps
    cyc(1, 0, 0, 4, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 255, 4, 0);
      if (i % 5 == 4) for (int g = 0; g < 3; g++) cyc(0, 0, 0, 4, 0);
    end
    pin(4080, 1);

    // Window change together with a sample
    cyc(1, 0, 0, 2, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, i, 2, 0);
    pin(10, 1);
    cyc(0, 1, 7, 1, 0);
    pin(7, 0);
    cyc(0, 1, 9, 1, 0);
    pin(16, 1);
    cyc(0, 1, 2, 1, 0);
    pin(11, 1);

    // Reset mid-stream with in_valid, then restart
    cyc(0, 1, 100, 1, 0);
    cyc(1, 1, 50, 1, 0);
    pin(0, 0);
    cyc(0, 1, 5, 1, 0);
    pin(5, 0);

    // Clamped selector behaves as W=16; W=1 echoes
    cyc(1, 0, 0, 7, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 10, 7, 0);
    pin(160, 1);
    cyc(0, 1, 42, 0, 0);
    pin(42, 1);
    cyc(0, 1, 17, 0, 0);
    pin(17, 1);

    // Randomized traffic
    sel = 2; m = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) sel = int'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) m = 1 - m;
      d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), d, sel, m[0]);
    end

    cyc(0, 0, 0, sel, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
